nrz_manchester_encoder_p: RTL and testbench

//   Parametrised word-to-line encoder. Accepts WIDTH-bit words over a valid/ready handshake
//   and serialises them onto one line output as Manchester or differential-Manchester code.
//   The clock runs at twice the bit rate, so each bit occupies two half-bit cycles.

---
 rtl/nrz_manchester_encoder_p.sv | 119 +++++++++++
 tb/tb_nrz_manchester_encoder_p.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/nrz_manchester_encoder_p.sv
// Word-to-line Manchester / differential-Manchester encoder with a valid/ready input.
// The clock runs at twice the bit rate; every output is registered.
module nrz_manchester_encoder_p #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  input  logic             mode,
  output logic             data_ready,
  output logic             b_out,
  output logic             b_out_en,
  output logic             word_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, H1, H2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shreg_adv;
  logic             mode_q, mode_d;
  logic             b_out_q, b_out_d;
  logic             b_out_en_q, b_out_en_d;
  logic             word_done_q, word_done_d;
  logic             last_bit;
  logic             xfer;

  // The bit on air is always kept at the head end of the shift register.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // H1 level of a bit; lvl is the level of the half-bit currently on the line.
  function automatic logic h1_level(input logic bit_v, input logic diff, input logic lvl);
    return diff ? ~(bit_v ^ lvl) : bit_v;
  endfunction

  generate
    if (MSB_FIRST) begin : g_msb
      assign shreg_adv = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign shreg_adv = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit   = (bit_cnt_q == LAST);
  assign data_ready = (state_q == IDLE) || ((state_q == H2) && last_bit);
  assign xfer       = data_valid && data_ready;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    mode_d    = mode_q;
    b_out_d   = IDLE_LEVEL;
    if (xfer) begin
      // In IDLE b_out_q already sits at IDLE_LEVEL, so a new frame and a
      // back-to-back word both take their reference level from b_out_q.
      state_d   = H1;
      bit_cnt_d = '0;
      shreg_d   = data_in;
      mode_d    = mode;
      b_out_d   = h1_level(head(data_in), mode, b_out_q);
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        H1: begin
          state_d = H2;
          b_out_d = ~b_out_q;
        end
        H2: begin
          if (!last_bit) begin
            state_d   = H1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            shreg_d   = shreg_adv;
            b_out_d   = h1_level(head(shreg_adv), mode_q, b_out_q);
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    b_out_en_d  = (state_d != IDLE);
    word_done_d = (state_d == H2) && (bit_cnt_d == LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      mode_q      <= 1'b0;
      b_out_q     <= IDLE_LEVEL;
      b_out_en_q  <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      mode_q      <= mode_d;
      b_out_q     <= b_out_d;
      b_out_en_q  <= b_out_en_d;
      word_done_q <= word_done_d;
    end
  end

  assign b_out     = b_out_q;
  assign b_out_en  = b_out_en_q;
  assign word_done = word_done_q;

endmodule

// File: tb/tb_nrz_manchester_encoder_p.sv
// Bench for nrz_manchester_encoder_p: queue-based line model checked every cycle,
// plus directed words with hand-computed line patterns.
module tb_nrz_manchester_encoder_p;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       mode = 1'b0;
  logic       data_valid = 1'b0;
  logic       lsb_valid = 1'b0;
  logic       il_valid = 1'b0;
  logic       ready_m, b_m, en_m, done_m;
  logic       ready_l, b_l, en_l, done_l;
  logic       ready_i, b_i, en_i, done_i;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  always #5 clock = ~clock;

  nrz_manchester_encoder_p #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid), .mode(mode),
    .data_ready(ready_m), .b_out(b_m), .b_out_en(en_m), .word_done(done_m));

  nrz_manchester_encoder_p #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(lsb_valid), .mode(mode),
    .data_ready(ready_l), .b_out(b_l), .b_out_en(en_l), .word_done(done_l));

  nrz_manchester_encoder_p #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_il (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(il_valid), .mode(mode),
    .data_ready(ready_i), .b_out(b_i), .b_out_en(en_i), .word_done(done_i));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of the main DUT: one queue entry per future half-bit cycle on the line.
  typedef struct packed {logic b; logic done;} ent_t;
  ent_t line_q[$];

  always @(posedge clock) begin
    ent_t popped;
    bit   had, xfer;
    logic lvl, h1;
    if (reset) begin
      line_q.delete();
    end else begin
      xfer = data_valid && (line_q.size() <= 1);
      had  = (line_q.size() > 0);
      popped = '0;
      if (had) popped = line_q.pop_front();
      if (xfer) begin
        lvl = had ? popped.b : 1'b0;
        for (int i = 0; i < 8; i++) begin
          h1 = mode ? (data_in[7-i] ? lvl : ~lvl) : data_in[7-i];
          line_q.push_back('{b: h1, done: 1'b0});
          line_q.push_back('{b: ~h1, done: (i == 7)});
          lvl = ~h1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("cyc_b_out",      b_m,     line_q.size() > 0 ? line_q[0].b : 1'b0);
      chk("cyc_b_out_en",   en_m,    line_q.size() > 0);
      chk("cyc_word_done",  done_m,  line_q.size() > 0 ? line_q[0].done : 1'b0);
      chk("cyc_data_ready", ready_m, line_q.size() <= 1);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Loads one word into the selected DUT and records the 16 coded half-bits.
  task automatic run_word(input int sel, input logic [7:0] d, input logic m, input bit perturb,
                          output logic [15:0] line, output logic [15:0] done);
    data_in = d;
    mode    = m;
    if (sel == 0) data_valid = 1'b1;
    else if (sel == 1) lsb_valid = 1'b1;
    else il_valid = 1'b1;
    step();
    data_valid = 1'b0;
    lsb_valid  = 1'b0;
    il_valid   = 1'b0;
    line = '0;
    done = '0;
    for (int i = 0; i < 16; i++) begin
      case (sel)
        0:       begin line = {line[14:0], b_m}; done = {done[14:0], done_m}; end
        1:       begin line = {line[14:0], b_l}; done = {done[14:0], done_l}; end
        default: begin line = {line[14:0], b_i}; done = {done[14:0], done_i}; end
      endcase
      if (perturb && i >= 1 && i <= 9) begin
        mode       = ~mode;
        data_in    = ~data_in;
        data_valid = (i % 2 == 1);
      end
      if (perturb && i == 10) data_valid = 1'b0;
      if (i < 15) step();
    end
    step();
  endtask

  initial begin
    logic [15:0] line, done;
    logic [31:0] l32, en32, rdy32;

    repeat (2) step();
    reset   = 1'b0;
    started = 1'b1;
    chk("rst_b_out", b_m, 1'b0);
    chk("rst_en", en_m, 1'b0);
    chk("rst_ready", ready_m, 1'b1);
    chk("rst_done", done_m, 1'b0);
    chk("rst_il_b_out", b_i, 1'b1);
    repeat (2) step();

    // T1 Manchester A5
    run_word(0, 8'hA5, 1'b0, 1'b0, line, done);
    chk("t1_line", line, 16'h9966);
    chk("t1_done", done, 16'h0001);
    chk("t1_idle_after", b_m, 1'b0);

    // T2 differential Manchester from idle
    run_word(0, 8'hFF, 1'b1, 1'b0, line, done);
    chk("t2_ff_line", line, 16'h6666);
    run_word(0, 8'h00, 1'b1, 1'b0, line, done);
    chk("t2_00_line", line, 16'hAAAA);

    // T3 back-to-back 3C then C3
    data_in = 8'h3C; mode = 1'b0; data_valid = 1'b1;
    step();
    data_in = 8'hC3;
    l32 = '0; en32 = '0; rdy32 = '0;
    for (int i = 0; i < 32; i++) begin
      l32 = {l32[30:0], b_m}; en32 = {en32[30:0], en_m}; rdy32 = {rdy32[30:0], ready_m};
      if (i == 16) data_valid = 1'b0;
      if (i < 31) step();
    end
    step();
    chk("t3_line", l32, 32'h5AA5A55A);
    chk("t3_en", en32, 32'hFFFFFFFF);
    chk("t3_ready", rdy32, 32'h00010001);
    chk("t3_idle_en", en_m, 1'b0);

    // Back-to-back differential words: level carries over (model-checked)
    data_in = 8'h0F; mode = 1'b1; data_valid = 1'b1;
    step();
    data_in = 8'hF0;
    repeat (16) step();
    data_valid = 1'b0;
    repeat (18) step();

    // T4 reset during H1 of bit 3
    data_in = 8'hF0; mode = 1'b0; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    repeat (6) step();
    chk("t4_pre_en", en_m, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t4_b_out", b_m, 1'b0);
    chk("t4_en", en_m, 1'b0);
    chk("t4_ready", ready_m, 1'b1);
    chk("t4_done", done_m, 1'b0);
    run_word(0, 8'h96, 1'b1, 1'b0, line, done);
    chk("t4_reload_line", line, 16'h569A);

    // T5 inputs toggled mid-word, and LSB-first variant
    run_word(0, 8'hB4, 1'b1, 1'b1, line, done);
    chk("t5_line", line, 16'h596A);
    chk("t5_done", done, 16'h0001);
    run_word(1, 8'h01, 1'b0, 1'b0, line, done);
    chk("t5_lsb_line", line, 16'h9555);
    chk("t5_lsb_done", done, 16'h0001);

    // T6 IDLE_LEVEL=1
    repeat (20) step();
    chk("t6_b_out", b_i, 1'b1);
    chk("t6_en", en_i, 1'b0);
    chk("t6_ready", ready_i, 1'b1);
    run_word(2, 8'hFF, 1'b1, 1'b0, line, done);
    chk("t6_diff_line", line, 16'h9999);
    chk("t6_b_out_after", b_i, 1'b1);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
